// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC unit: PC width, redirect FSM states and
// exe_correction codes.
package next_pc_unit_pkg;

  localparam int unsigned PcW = 10;

  typedef logic [PcW-1:0] pc_t;

  typedef enum logic {
    StRun,
    StPending
  } npc_state_e;

  // exe_correction encodings; bit 1 set means a redirect is requested.
  localparam logic [1:0] CorrNone0 = 2'b00;
  localparam logic [1:0] CorrNone1 = 2'b01;
  localparam logic [1:0] CorrCni   = 2'b10;
  localparam logic [1:0] CorrPbt   = 2'b11;

endpackage

// File: rtl/next_pc_unit_sat_counter.sv
// Saturating up-counter.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low clear
//   inc_i    : increment by one on this rising edge (stops at all-ones)
//   count_o  : current count
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/next_pc_unit.sv
// Next fetch-PC selection with stall-tolerant redirect and perf counters.
//   CLK, nrst        : clock, asynchronous active-low reset
//   if_stall         : hold PC this cycle
//   if_prediction    : predictor says taken; if_PBT is the predicted target
//   exe_correction   : 1x = redirect (10 -> exe_CNI, 11 -> exe_PBT)
//   exe_is_btype     : a conditional branch resolves this cycle
//   if_PC            : registered fetch word address
//   flush            : kill IF/ID, equals exe_correction[1] combinationally
//   branch_cnt       : saturating count of resolved conditional branches
//   mispredict_cnt   : saturating count of corrections
// A correction arriving while stalled is parked in pend_target and applied
// on the first unstalled edge; the first parked target wins over later ones.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter logic [PcW-1:0] RESET_PC = 10'h000,
  parameter int unsigned    CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nrst,
  input  logic             if_stall,
  input  logic             if_prediction,
  input  logic [PcW-1:0]   if_PBT,
  input  logic [1:0]       exe_correction,
  input  logic [PcW-1:0]   exe_PBT,
  input  logic [PcW-1:0]   exe_CNI,
  input  logic             exe_is_btype,
  output logic [PcW-1:0]   if_PC,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  npc_state_e state_q, state_d;
  pc_t        pc_q, pc_d;
  pc_t        pend_target_q, pend_target_d;

  logic corr_valid;
  pc_t  corr_target;

  assign corr_valid  = exe_correction[1];
  assign corr_target = (exe_correction == CorrPbt) ? exe_PBT : exe_CNI;
  assign flush       = corr_valid;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;

    unique case (state_q)
      StRun: begin
        if (corr_valid) begin
          if (if_stall) begin
            pend_target_d = corr_target;
            state_d       = StPending;
          end else begin
            pc_d = corr_target;
          end
        end else if (!if_stall) begin
          pc_d = if_prediction ? if_PBT : pc_q + PcW'(1);
        end
      end
      StPending: begin
        // A fresh correction on the release cycle is younger and overrides.
        if (!if_stall) begin
          pc_d    = corr_valid ? corr_target : pend_target_q;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign if_PC = pc_q;

  sat_counter #(
    .Width (CNT_W)
  ) u_branch_cnt (
    .clk_i   (CLK),
    .rst_ni  (nrst),
    .inc_i   (exe_is_btype),
    .count_o (branch_cnt)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_mispredict_cnt (
    .clk_i   (CLK),
    .rst_ni  (nrst),
    .inc_i   (corr_valid),
    .count_o (mispredict_cnt)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

  logic       CLK;
  logic       nrst;
  logic       if_stall;
  logic       if_prediction;
  logic [9:0] if_PBT;
  logic [1:0] exe_correction;
  logic [9:0] exe_PBT;
  logic [9:0] exe_CNI;
  logic       exe_is_btype;

  logic [9:0]  if_PC;
  logic        flush;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  logic [9:0]  if_PC_n4;
  logic        flush_n4;
  logic [3:0]  branch_cnt_n4;
  logic [3:0]  mispredict_cnt_n4;

  int n_checks = 0;
  int n_pass   = 0;

  next_pc_unit #(
    .RESET_PC (10'h000),
    .CNT_W    (16)
  ) dut (
    .CLK            (CLK),
    .nrst           (nrst),
    .if_stall       (if_stall),
    .if_prediction  (if_prediction),
    .if_PBT         (if_PBT),
    .exe_correction (exe_correction),
    .exe_PBT        (exe_PBT),
    .exe_CNI        (exe_CNI),
    .exe_is_btype   (exe_is_btype),
    .if_PC          (if_PC),
    .flush          (flush),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation.
  next_pc_unit #(
    .RESET_PC (10'h000),
    .CNT_W    (4)
  ) dut_n4 (
    .CLK            (CLK),
    .nrst           (nrst),
    .if_stall       (if_stall),
    .if_prediction  (if_prediction),
    .if_PBT         (if_PBT),
    .exe_correction (exe_correction),
    .exe_PBT        (exe_PBT),
    .exe_CNI        (exe_CNI),
    .exe_is_btype   (exe_is_btype),
    .if_PC          (if_PC_n4),
    .flush          (flush_n4),
    .branch_cnt     (branch_cnt_n4),
    .mispredict_cnt (mispredict_cnt_n4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nrst           = 1'b0;
    if_stall       = 1'b0;
    if_prediction  = 1'b0;
    if_PBT         = 10'h000;
    exe_correction = 2'b00;
    exe_PBT        = 10'h000;
    exe_CNI        = 10'h000;
    exe_is_btype   = 1'b0;

    #1;
    check_eq("rst_pc", 32'(if_PC), 32'h000);
    tick();
    tick();
    check_eq("rst_bcnt", 32'(branch_cnt), 32'h0);
    check_eq("rst_mcnt", 32'(mispredict_cnt), 32'h0);
    check_eq("rst_flush", 32'(flush), 32'h0);

    // Release away from the edge; first fetch is RESET_PC.
    #2 nrst = 1'b1;
    #1;
    check_eq("seq_pc0", 32'(if_PC), 32'h000);
    tick(); check_eq("seq_pc1", 32'(if_PC), 32'h001);
    tick(); check_eq("seq_pc2", 32'(if_PC), 32'h002);
    tick(); check_eq("seq_pc3", 32'(if_PC), 32'h003);
    check_eq("seq_bcnt", 32'(branch_cnt), 32'h0);
    check_eq("seq_mcnt", 32'(mispredict_cnt), 32'h0);

    // Prediction taken to 3FF, then sequential wrap.
    if_prediction = 1'b1;
    if_PBT        = 10'h3FF;
    tick(); check_eq("pred_3ff", 32'(if_PC), 32'h3FF);
    if_prediction = 1'b0;
    tick(); check_eq("wrap_000", 32'(if_PC), 32'h000);

    // Get to 010, then correction beats the prediction.
    if_prediction = 1'b1;
    if_PBT        = 10'h010;
    tick(); check_eq("pred_010", 32'(if_PC), 32'h010);
    if_PBT         = 10'h080;
    exe_correction = 2'b10;
    exe_CNI        = 10'h021;
    #1;
    check_eq("flush_corr", 32'(flush), 32'h1);
    tick();
    check_eq("corr_pc", 32'(if_PC), 32'h021);
    check_eq("corr_mcnt", 32'(mispredict_cnt), 32'h1);
    exe_correction = 2'b00;
    if_prediction  = 1'b0;
    #1;
    check_eq("flush_clr", 32'(flush), 32'h0);

    // Plain stall holds PC.
    if_stall = 1'b1;
    tick(); check_eq("stall_hold", 32'(if_PC), 32'h021);

    // Stall window with two corrections; first captured wins.
    exe_correction = 2'b11;
    exe_PBT        = 10'h150;
    #1;
    check_eq("flush_stall", 32'(flush), 32'h1);
    tick(); check_eq("pend_hold1", 32'(if_PC), 32'h021);
    exe_correction = 2'b10;
    exe_CNI        = 10'h0AA;
    tick(); check_eq("pend_hold2", 32'(if_PC), 32'h021);
    exe_correction = 2'b00;
    tick(); check_eq("pend_hold3", 32'(if_PC), 32'h021);
    if_stall      = 1'b0;
    if_prediction = 1'b1;
    if_PBT        = 10'h200;
    tick(); check_eq("pend_apply", 32'(if_PC), 32'h150);
    check_eq("pend_mcnt", 32'(mispredict_cnt), 32'h3);
    if_prediction = 1'b0;
    tick(); check_eq("post_pend", 32'(if_PC), 32'h151);

    // Enter PENDING, then reset discards it.
    if_stall       = 1'b1;
    exe_correction = 2'b11;
    exe_PBT        = 10'h150;
    tick();
    exe_correction = 2'b00;
    check_eq("pend2_hold", 32'(if_PC), 32'h151);
    #1 nrst = 1'b0;
    #1;
    check_eq("async_rst_pc", 32'(if_PC), 32'h000);
    check_eq("async_rst_mcnt", 32'(mispredict_cnt), 32'h0);
    exe_correction = 2'b10;
    #1;
    check_eq("flush_in_rst", 32'(flush), 32'h1);
    exe_correction = 2'b00;
    if_stall       = 1'b0;
    #1 nrst = 1'b1;
    #1;
    check_eq("rel_pc0", 32'(if_PC), 32'h000);
    tick(); check_eq("rel_pc1", 32'(if_PC), 32'h001);

    // Saturation: 20 edges of branch + correction.
    exe_is_btype   = 1'b1;
    exe_correction = 2'b11;
    exe_PBT        = 10'h040;
    for (int i = 0; i < 15; i++) tick();
    check_eq("n4_bcnt_15", 32'(branch_cnt_n4), 32'hF);
    for (int i = 0; i < 5; i++) tick();
    check_eq("n4_bcnt_sat", 32'(branch_cnt_n4), 32'hF);
    check_eq("n4_mcnt_sat", 32'(mispredict_cnt_n4), 32'hF);
    check_eq("w16_bcnt_20", 32'(branch_cnt), 32'd20);
    check_eq("w16_mcnt_20", 32'(mispredict_cnt), 32'd20);
    check_eq("corr_pbt_pc", 32'(if_PC), 32'h040);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 10'h000, word address loaded into the PC on reset.
REQ-002 Parameter CNT_W, default 16, width of each performance counter.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 if_stall  in  1  hold the PC this cycle (pipeline hazard).
REQ-006 if_prediction  in  1  branch predictor says taken for current if_PC.
REQ-007 if_PBT  in  10  predicted branch target for current if_PC.
REQ-008 exe_correction  in  2  00/01 = none; 10 = redirect to exe_CNI; 11 = redirect to exe_PBT.
REQ-009 exe_PBT  in  10  taken target of the resolving branch.
REQ-010 exe_CNI  in  10  fall-through address of the resolving branch.
REQ-011 exe_is_btype  in  1  a conditional branch is resolving in EXE this cycle.
REQ-012 if_PC  out  10  current fetch word address (registered).
REQ-013 flush  out  1  kill IF/ID-stage instructions; combinational.
REQ-014 branch_cnt  out  CNT_W  resolved conditional branches (saturating).
REQ-015 mispredict_cnt  out  CNT_W  corrections issued (saturating).

Function
REQ-016 Addresses are 10-bit word addresses; sequential next PC = if_PC + 1, modulo 2^10 (10'h3FF wraps to 10'h000).
REQ-017 next-PC priority: exe correction > pending redirect > if_prediction (if_PBT) > if_PC + 1.
REQ-018 flush SHALL equal exe_correction[1], same cycle, independent of if_stall and state.
REQ-019 FSM states: RUN, PENDING; reset state RUN.
REQ-020 RUN, exe_correction[1]=1, if_stall=0: if_PC <= selected target next edge; stay RUN.
REQ-021 RUN, exe_correction[1]=1, if_stall=1: if_PC holds; target captured in pend_target; go PENDING.
REQ-022 RUN, no correction, if_stall=1: if_PC holds, no other state change.
REQ-023 PENDING, if_stall=1: if_PC holds; pend_target unchanged, including when another correction arrives (first-captured wins).
REQ-024 PENDING, if_stall=0: if_PC <= pend_target (or new exe target if exe_correction[1]=1 same cycle); go RUN.
REQ-025 if_prediction is ignored whenever a correction or pending redirect applies.
REQ-026 branch_cnt increments by 1 on each edge with exe_is_btype=1; mispredict_cnt on each edge with exe_correction[1]=1; neither depends on if_stall; both saturate at all-ones.
REQ-027 Latency: redirect visible on if_PC one edge after the correction (unstalled), or one edge after if_stall falls (pending).

Reset
REQ-028 nrst low asynchronously forces if_PC=RESET_PC, state=RUN, pend_target=0, branch_cnt=0, mispredict_cnt=0.
REQ-029 Reset mid-PENDING SHALL discard the pending redirect; flush follows exe_correction even during reset.
REQ-030 First fetch after nrst release is RESET_PC; PC advances on first edge with nrst high and if_stall=0.

Structure
REQ-031 Shared package holds: FSM state encoding (RUN, PENDING), exe_correction codes (CORR_CNI=2'b10, CORR_PBT=2'b11), PC width constant 10.
REQ-032 One sub-module: sat_counter (parameter width, inc, async active-low clear), instantiated twice.
REQ-033 Target mux combinational; if_PC, state, pend_target registered only.

Verification
REQ-034 Reset release, no stall/prediction, 4 cycles -> if_PC 000,001,002,003; counters 0.
REQ-035 if_PC=10'h3FF, no prediction -> next if_PC=10'h000.
REQ-036 if_PC=10'h010, if_prediction=1, if_PBT=10'h080, simultaneous exe_correction=2'b10, exe_CNI=10'h021 -> flush=1 same cycle, if_PC=10'h021, mispredict_cnt=1.
REQ-037 if_stall=1 for 3 cycles, exe_correction=2'b11 (exe_PBT=10'h150) in stall cycle 1, 2'b10 (exe_CNI=10'h0AA) in stall cycle 2 -> if_PC held, then 10'h150 one edge after if_stall falls.
REQ-038 Enter PENDING (target 10'h150), pulse nrst low -> if_PC=RESET_PC immediately, state RUN, target lost after release.
REQ-039 CNT_W=4, exe_is_btype=1 and exe_correction=2'b11 for 20 edges -> both counters stick at 4'hF.
